accel_spi_responder: RTL
========================

ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

Interface
REQ-001 Parameter DEVID, default 8'hE5, value returned at address 0x00.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on csn/sclk/sdi.
REQ-003 clk  input  1  system clock; must run at least 8x the SPI clock rate.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 spi_csn  input  1  SPI chip select, active low.
REQ-006 spi_sclk  input  1  SPI clock, mode 3 (idles high).
REQ-007 spi_sdi  input  1  master-to-responder serial data.
REQ-008 spi_sdo  output  1  responder-to-master serial data.
REQ-009 spi_sdo_oe  output  1  SDO drive enable for the top-level tristate.
REQ-010 sample_x, sample_y, sample_z  input  16 each  new axis samples, two's complement.
REQ-011 sample_valid  input  1  one-cycle strobe qualifying the sample_* inputs.
REQ-012 int1  output  1  data-ready interrupt, active high.
REQ-013 bw_rate, power_ctl, data_format  output  8 each  current register contents.

Function
REQ-014 SHALL pass csn, sclk, and sdi through SYNC_STAGES flops, then detect sclk rise, sclk fall, and csn fall/rise, each as a one-cycle pulse.
REQ-015 FSM states: IDLE, CMD, DATA. IDLE->CMD on csn fall. CMD->DATA after 8th sclk rise. DATA stays in DATA per byte. Any state->IDLE on csn rise.
REQ-016 Command byte, MSB first: bit7 R/W (1=read), bit6 MB, bits5:0 start address.
REQ-017 SHALL sample sdi on the synchronized sclk rise and update sdo within 2 clk cycles of the synchronized sclk fall.
REQ-018 Read: first data MSB driven after the sclk fall that follows the 8th command rise. spi_sdo_oe=1 only in DATA with R/W=1.
REQ-019 After each complete data byte: address+1 if MB=1 (0x3F wraps to 0x00), otherwise address held.
REQ-020 Write: commit the byte to the register on its 8th rise. Writes to read-only or unimplemented addresses are ignored.
REQ-021 Register map:
- 0x00 DEVID (RO)
- 0x2C bw_rate (RW, reset 0x0A)
- 0x2D power_ctl (RW, reset 0x00)
- 0x31 data_format (RW, reset 0x00)
- 0x32..0x37 X0,X1,Y0,Y1,Z0,Z1 (RO, little-endian per axis)
- all other addresses read 0x00
REQ-022 sample_valid with csn high SHALL load the data registers on the next cycle and set int1.
REQ-023 sample_valid with csn low SHALL be held in a pending buffer. The buffer loads 1 cycle after csn rise. A newer pending sample overwrites an older one. This keeps multi-byte reads coherent.
REQ-024 int1 SHALL clear when a read command addressing 0x32..0x37 completes its command byte. A simultaneous set and clear resolves to set.
REQ-025 sample_* SHALL be ignored when power_ctl[3]=0 (standby).
REQ-026 csn rise mid-byte SHALL abort the byte: a partial write is discarded, the bit counter clears, and sdo_oe drops within 1 cycle.

Reset
REQ-027 On rst: state=IDLE, bit counter=0, address=0, spi_sdo=0, spi_sdo_oe=0, int1=0, pending buffer empty, data registers=0, and the RW registers take the REQ-021 reset values.
REQ-028 rst asserted mid-transaction SHALL abort it. After rst deasserts, the block waits for a fresh csn fall.

Structure
REQ-029 Shared package accel_regs_pkg holds:
- register address constants
- register reset values
- the FSM state enum
REQ-030 One sub-module, spi_sync_edge: parameterized synchronizer plus rise/fall pulse generator, instantiated per SPI input.

Verification
REQ-031 Read 0x00 (command 0x80) -> byte 0xE5 on sdo; spi_sdo_oe high only during the data byte.
REQ-032 sample_x=0x01FF, y=0xFE00, z=0x0100 with power_ctl=0x08, then MB read from 0x32 (command 0xF2), 6 bytes -> FF 01 00 FE 00 01; int1 clears after the command byte.
REQ-033 Write 0x2D=0x08 (command 0x2D, data 0x08) -> power_ctl=0x08. Write 0x00=0x12 -> DEVID still reads 0xE5.
REQ-034 sample_valid during an MB read (x=0x1234) -> read bytes show the old data. A following read shows 34 12, and int1 is set after csn rise.
REQ-035 csn rise after 5 bits of a write to 0x31 -> data_format unchanged. The next full transaction decodes correctly.
REQ-036 MB read from 0x3F for 2 bytes -> 0x00 then 0xE5 (address wrap); rst mid-byte -> sdo_oe=0 and registers at reset values.

Source files
------------

// File: rtl/accel_regs_pkg.sv
// accel_regs_pkg: register map, reset values and FSM states shared by the accelerometer SPI responder.
package accel_regs_pkg;
   localparam logic [5:0] ADDR_DEVID       = 6'h00;
   localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
   localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
   localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
   localparam logic [5:0] ADDR_DATAX0      = 6'h32;
   localparam logic [5:0] ADDR_DATAZ1      = 6'h37;
   localparam logic [7:0] RST_BW_RATE      = 8'h0A;
   localparam logic [7:0] RST_POWER_CTL    = 8'h00;
   localparam logic [7:0] RST_DATA_FORMAT  = 8'h00;
   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_e;
   function automatic logic is_data_addr(input logic [5:0] a);
      return a >= ADDR_DATAX0 && a <= ADDR_DATAZ1;
   endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: synchronizer chain plus one-cycle rise/fall pulses for one asynchronous SPI pin.
// The chain free-runs through reset so a pin already low at reset release does not look like a fresh edge.
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);
   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   always_ff @(posedge clk) begin
      sync_q <= STAGES'({sync_q, d_i});
      prev_q <= sync_q[STAGES-1];
   end
   assign q_o    = sync_q[STAGES-1];
   assign rise_o = q_o & ~prev_q;
   assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/accel_spi_responder.sv
// accel_spi_responder: mode-3 SPI register slave for an accelerometer, with coherent sample buffering
// and a data-ready interrupt.
module accel_spi_responder
   import accel_regs_pkg::*;
#(
   parameter logic [7:0] DEVID       = 8'hE5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_csn,
   input  logic        spi_sclk,
   input  logic        spi_sdi,
   output logic        spi_sdo,
   output logic        spi_sdo_oe,
   input  logic [15:0] sample_x,
   input  logic [15:0] sample_y,
   input  logic [15:0] sample_z,
   input  logic        sample_valid,
   output logic        int1,
   output logic [7:0]  bw_rate,
   output logic [7:0]  power_ctl,
   output logic [7:0]  data_format
);
   logic csn_s, csn_rise, csn_fall, sclk_s, sclk_rise, sclk_fall, sdi_s, sdi_r, sdi_f;
   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csn  (.clk(clk), .d_i(spi_csn),  .q_o(csn_s),  .rise_o(csn_rise),  .fall_o(csn_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .d_i(spi_sclk), .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sdi  (.clk(clk), .d_i(spi_sdi),  .q_o(sdi_s),  .rise_o(sdi_r),     .fall_o(sdi_f));
   logic unused_s;
   assign unused_s = &{1'b0, sclk_s, sdi_r, sdi_f};
   state_e      state_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  shift_q, bw_rate_q, power_ctl_q, data_format_q;
   logic [5:0]  addr_q;
   logic        rw_q, mb_q, sdo_q, oe_q, int1_q, pend_v_q;
   logic [47:0] data_q, pend_q;
   logic [7:0]  rx_byte, rd_byte;
   logic [2:0]  off;
   logic        samp_en;
   always_comb begin
      rx_byte = {shift_q[6:0], sdi_s};
      off     = 3'(addr_q - ADDR_DATAX0);
      samp_en = sample_valid & power_ctl_q[3];
      rd_byte = addr_q == ADDR_DEVID       ? DEVID :
                addr_q == ADDR_BW_RATE     ? bw_rate_q :
                addr_q == ADDR_POWER_CTL   ? power_ctl_q :
                addr_q == ADDR_DATA_FORMAT ? data_format_q :
                is_data_addr(addr_q)       ? data_q[{off, 3'b000} +: 8] : 8'h00;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         addr_q        <= '0;
         rw_q          <= 1'b0;
         mb_q          <= 1'b0;
         sdo_q         <= 1'b0;
         oe_q          <= 1'b0;
         int1_q        <= 1'b0;
         pend_v_q      <= 1'b0;
         pend_q        <= '0;
         data_q        <= '0;
         bw_rate_q     <= RST_BW_RATE;
         power_ctl_q   <= RST_POWER_CTL;
         data_format_q <= RST_DATA_FORMAT;
      end else begin
         if (csn_rise) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            oe_q      <= 1'b0;
            sdo_q     <= 1'b0;
            if (pend_v_q) begin
               data_q   <= pend_q;
               pend_v_q <= 1'b0;
               int1_q   <= 1'b1;
            end
         end else if (csn_fall) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= '0;
         end else if (state_q != ST_IDLE) begin
            if (sclk_rise) begin
               shift_q   <= rx_byte;
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7 && state_q == ST_CMD) begin
                  state_q <= ST_DATA;
                  rw_q    <= shift_q[6];
                  mb_q    <= shift_q[5];
                  addr_q  <= rx_byte[5:0];
                  oe_q    <= shift_q[6];
                  if (shift_q[6] && is_data_addr(rx_byte[5:0])) int1_q <= 1'b0;
               end else if (bit_cnt_q == 3'd7) begin
                  if (!rw_q && addr_q == ADDR_BW_RATE) bw_rate_q <= rx_byte;
                  if (!rw_q && addr_q == ADDR_POWER_CTL) power_ctl_q <= rx_byte;
                  if (!rw_q && addr_q == ADDR_DATA_FORMAT) data_format_q <= rx_byte;
                  if (mb_q) addr_q <= addr_q + 6'd1;
               end
            end
            if (sclk_fall && state_q == ST_DATA && rw_q) sdo_q <= rd_byte[~bit_cnt_q];
         end
         // Samples arriving mid-transaction wait in the pending buffer so a burst read stays coherent.
         if (samp_en && !csn_s) begin
            pend_q   <= {sample_z, sample_y, sample_x};
            pend_v_q <= 1'b1;
         end else if (samp_en) begin
            data_q <= {sample_z, sample_y, sample_x};
            int1_q <= 1'b1;
         end
      end
   end
   assign spi_sdo     = sdo_q;
   assign spi_sdo_oe  = oe_q;
   assign int1        = int1_q;
   assign bw_rate     = bw_rate_q;
   assign power_ctl   = power_ctl_q;
   assign data_format = data_format_q;
endmodule
